act_frame_feeder: RTL and testbench
===================================

# act_frame_feeder

Streaming-to-parallel activation feeder for one neuron node of the fully connected layers. It accepts 32-bit IEEE-754 single-precision activations one word per cycle over a valid/ready stream with a frame-end marker. It assembles each frame of N_IN words and presents it as a stable parallel bus for a node's A0..A(N_IN-1) inputs. It is the writer side of the node's parallel activation interface, double-buffered so filling the next frame overlaps consumption of the current one.

## Interface
- N_IN, 15: activations per frame; node fan-in; legal range 2..64.
- DW, 32: word width; fixed IEEE-754 single; data passes through untouched.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- s_data  in  DW  incoming activation word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final word of a frame; qualified by s_valid.
- s_ready  out  1  feeder accepts a word this cycle.
- m_a  out  N_IN*DW  parallel frame; slot i at bits [i*DW +: DW]; slot 0 maps to A0.
- m_valid  out  1  m_a holds a complete frame.
- m_ready  in  1  node side consumed the frame.
- err_short  out  1  one-cycle pulse: s_last arrived before slot N_IN-1; frame dropped.
- err_long  out  1  one-cycle pulse: slot N_IN-1 was filled without s_last; excess words discarded.
- frame_cnt  out  16  count of frames delivered (m_valid & m_ready); wraps 0xFFFF -> 0.

## Operation
- Storage: fill buffer of N_IN words, output register bank driving m_a, and slot counter wr_idx (0..N_IN-1).
- A word is accepted when s_valid & s_ready; it is written to fill slot wr_idx.
- FSM states:
  - FILL: s_ready=1.
    - Accept at wr_idx<N_IN-1 with s_last=0: wr_idx++.
    - Accept at wr_idx<N_IN-1 with s_last=1: err_short pulse, wr_idx<=0, stay FILL; the partial frame is never presented.
    - Accept at wr_idx=N_IN-1: frame complete, wr_idx<=0.
      - With s_last=1: commit if the output bank is free, else go to FULL.
      - With s_last=0: err_long pulse, commit if free, else go to FULL; the subsequent path passes through DISCARD (below).
  - FULL: s_ready=0. Commit when the output bank is free, then go to FILL, or to DISCARD if the frame ended without s_last.
  - DISCARD: s_ready=1. Accepted words are dropped, with no slot writes. Accepting a word with s_last=1 goes to FILL.
- Output bank is free when !m_valid | m_ready.
- Commit: m_a <= fill buffer, m_valid <= 1.
- m_valid clears on m_ready when no commit happens in the same cycle.
- While m_valid=1 and m_ready=0, m_a and m_valid hold stable; there is no retraction.
- Unused slots never exist: every presented frame has all N_IN slots written in this frame.

## Timing
- Reset (asynchronous, applied immediately):
  - State=FILL, wr_idx=0, m_valid=0, m_a=0, frame_cnt=0, err_short=err_long=0.
  - s_ready=1 once state=FILL, and is combinational from state.
- Latency: last word accepted at edge t with the bank free -> m_valid=1 and m_a valid after edge t.
- Simultaneous commit and consume (m_valid & m_ready in the commit cycle): the new frame replaces the old one, and m_valid stays 1.
- Sustained throughput: one frame per N_IN cycles with zero bubbles when m_ready=1.
- When blocked, s_ready deasserts the cycle after the final word is accepted. It reasserts the cycle after the commit.
- Error pulses are asserted for exactly one cycle, in the cycle after the offending accept.
- Reset mid-frame: the partial frame and any pending output are lost, and no error is flagged.

## Structure
- Shared package nn_layer_pkg: DW, default N_IN, FSM state enum (FILL, FULL, DISCARD), float word typedef.
- Single module; no sub-module. The fill buffer and output bank are flat register arrays.

## Test plan
- Frame 1.0..15.0 (0x3F800000..0x41700000), s_last on the 15th word, m_ready=1 -> m_valid the cycle after; slot0=0x3F800000, slot14=0x41700000; frame_cnt=1.
- Back-to-back 4 frames with m_ready=1 -> 4 frames in 60+1 cycles, s_ready never low, frame_cnt=4.
- m_ready=0 for 40 cycles during a second frame -> s_ready drops after word 15; m_a holds frame 1 bit-exact; on m_ready=1 frame 2 appears the next cycle.
- s_last on word 7 -> err_short pulse, no m_valid; the next 15-word frame is delivered correctly.
- 18-word frame with s_last on word 18 -> the first 15 words are delivered, err_long pulse, words 16-18 dropped; the next frame starts at slot 0.
- rst_n low at word 9 with m_valid=1 -> m_valid=0 and m_a=0 immediately; a fresh frame after reset is delivered intact.

Source files
------------

// File: rtl/nn_layer_pkg.sv
// Shared types for the fully connected layer datapath: word width, default fan-in,
// and the activation feeder FSM states.
package nn_layer_pkg;
  localparam int DW       = 32;
  localparam int N_IN_DEF = 15;

  typedef logic [DW-1:0] fp32_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FULL,
    ST_DISCARD
  } state_e;
endpackage

// File: rtl/act_frame_feeder.sv
// Streaming-to-parallel activation feeder: assembles N_IN-word frames into a fill
// buffer and commits them to a stable output bank for a node's A0..A(N_IN-1) inputs.
module act_frame_feeder
  import nn_layer_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [N_IN*DW-1:0]   m_a,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err_short,
  output logic                 err_long,
  output logic [15:0]          frame_cnt
);

  localparam int IW = $clog2(N_IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          wr_idx_q, wr_idx_d;
  fp32_t [N_IN-1:0]       fill_q, fill_d;
  fp32_t [N_IN-1:0]       bank_q, bank_d;
  logic                   m_valid_q, m_valid_d;
  logic                   long_q, long_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   accept, bank_free, commit;

  assign s_ready   = (state_q != ST_FULL);
  assign accept    = s_valid & s_ready;
  assign bank_free = ~m_valid_q | m_ready;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    fill_d      = fill_q;
    bank_d      = bank_q;
    m_valid_d   = m_valid_q;
    long_d      = long_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    commit      = 1'b0;
    frame_cnt_d = frame_cnt_q + 16'(m_valid_q & m_ready);

    if (m_valid_q & m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          fill_d[wr_idx_q] = s_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d   = '0;
            err_long_d = ~s_last;
            if (bank_free) begin
              commit  = 1'b1;
              state_d = s_last ? ST_FILL : ST_DISCARD;
            end else begin
              state_d = ST_FULL;
              long_d  = ~s_last;
            end
          end else if (s_last) begin
            // Short frame: rewind and never present the partial contents.
            err_short_d = 1'b1;
            wr_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bank_free) begin
          commit  = 1'b1;
          state_d = long_q ? ST_DISCARD : ST_FILL;
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase

    // Commit takes fill_d so the word accepted this cycle lands in the bank too.
    if (commit) begin
      bank_d    = fill_d;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wr_idx_q    <= '0;
      fill_q      <= '0;
      bank_q      <= '0;
      m_valid_q   <= 1'b0;
      long_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      fill_q      <= fill_d;
      bank_q      <= bank_d;
      m_valid_q   <= m_valid_d;
      long_q      <= long_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_a       = bank_q;
  assign m_valid   = m_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_act_frame_feeder.sv
// Directed bench for act_frame_feeder: queue-based frame model checked every cycle,
// plus hand-computed literal checks on key cycles.
module tb_act_frame_feeder;
  localparam int N  = 15;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_last = 1'b0;
  logic                s_ready;
  logic [N*DW-1:0]     m_a;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic                err_short;
  logic                err_long;
  logic [15:0]         frame_cnt;

  act_frame_feeder #(.N_IN(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_a(m_a), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int stalls = 0;

  // Frame-level model state
  logic [31:0]          fq[$];
  logic [N-1:0][31:0]   pend, mdl_ma, cf;
  bit                   mdl_pend, mdl_plong, mdl_drop, mdl_mv, mdl_es, mdl_el;
  bit                   fr, free, acc, commit;
  logic [15:0]          mdl_cnt;

  function automatic logic [31:0] fbits(input int k);
    int e;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [N-1:0][31:0] pack(input logic [31:0] q[$]);
    logic [N-1:0][31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fq.delete();
        mdl_pend = 0; mdl_plong = 0; mdl_drop = 0; mdl_mv = 0;
        mdl_es = 0; mdl_el = 0; mdl_cnt = '0; mdl_ma = '0; pend = '0;
      end else begin
        fr = mdl_mv && m_ready;
        free = !mdl_mv || m_ready;
        acc = s_valid && !mdl_pend;
        commit = 0; mdl_es = 0; mdl_el = 0; cf = '0;
        if (mdl_pend) begin
          if (free) begin
            commit = 1; cf = pend; mdl_pend = 0; mdl_drop = mdl_plong;
          end
        end else if (acc) begin
          if (mdl_drop) begin
            if (s_last) mdl_drop = 0;
          end else begin
            fq.push_back(s_data);
            if (fq.size() == N) begin
              cf = pack(fq);
              fq.delete();
              mdl_el = !s_last;
              if (free) begin
                commit = 1; mdl_drop = !s_last;
              end else begin
                pend = cf; mdl_pend = 1; mdl_plong = !s_last;
              end
            end else if (s_last) begin
              mdl_es = 1;
              fq.delete();
            end
          end
        end
        if (fr) mdl_cnt++;
        if (commit) begin
          mdl_ma = cf; mdl_mv = 1;
        end else if (fr) begin
          mdl_mv = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mon_s_ready", 64'(s_ready), 64'(!mdl_pend));
        chk("mon_m_valid", 64'(m_valid), 64'(mdl_mv));
        chk("mon_err_short", 64'(err_short), 64'(mdl_es));
        chk("mon_err_long", 64'(err_long), 64'(mdl_el));
        chk("mon_frame_cnt", 64'(frame_cnt), 64'(mdl_cnt));
        tests++;
        if (m_a !== mdl_ma) begin
          fails++;
          for (int i = 0; i < N; i++)
            if (m_a[i*DW +: DW] !== mdl_ma[i]) begin
              $display("FAIL mon_m_a slot %0d: got %0h expected %0h", i, m_a[i*DW +: DW], mdl_ma[i]);
              break;
            end
        end
      end
    end
  end

  initial begin : stall_mon
    forever begin
      @(posedge clk);
      if (rst_n && s_valid && !s_ready) stalls++;
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic l);
    bit rdy;
    int n;
    s_valid = 1'b1; s_data = d; s_last = l; n = 0;
    forever begin
      rdy = s_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        fails++; tests++;
        $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  int st0;

  initial begin : stim
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_a", 64'(|m_a), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // 1.0 .. 15.0
    for (int i = 0; i < N; i++) send_word(fbits(i + 1), i == N - 1);
    idle();
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_slot0", 64'(m_a[0 +: DW]), 64'h3F80_0000);
    chk("t1_slot14", 64'(m_a[14*DW +: DW]), 64'h4170_0000);
    @(negedge clk);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Four back-to-back frames
    st0 = stalls;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) send_word({8'hA0 + 8'(f), 24'(i)}, i == N - 1);
    idle();
    chk("t2_last_slot14", 64'(m_a[14*DW +: DW]), 64'hA300_000E);
    @(negedge clk);
    chk("t2_no_stalls", 64'(stalls - st0), 64'd0);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd5);

    // Backpressure: frame B blocked behind held frame A
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) send_word(32'hB000_0000 + i, i == N - 1);
    for (int i = 0; i < N; i++) send_word(32'hC000_0000 + i, i == N - 1);
    idle();
    chk("t3_s_ready_low", 64'(s_ready), 64'd0);
    repeat (40) @(negedge clk);
    chk("t3_hold_valid", 64'(m_valid), 64'd1);
    chk("t3_hold_slot0", 64'(m_a[0 +: DW]), 64'hB000_0000);
    chk("t3_hold_slot14", 64'(m_a[14*DW +: DW]), 64'hB000_000E);
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_new_slot0", 64'(m_a[0 +: DW]), 64'hC000_0000);
    chk("t3_new_valid", 64'(m_valid), 64'd1);
    chk("t3_s_ready_back", 64'(s_ready), 64'd1);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd6);
    @(negedge clk);
    chk("t3_frame_cnt2", 64'(frame_cnt), 64'd7);

    // Short frame of 7 words
    for (int i = 0; i < 7; i++) send_word(32'h0000_00D0 + i, i == 6);
    idle();
    chk("t4_err_short", 64'(err_short), 64'd1);
    chk("t4_no_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("t4_err_short_clr", 64'(err_short), 64'd0);
    for (int i = 0; i < N; i++) send_word(32'h0000_0E00 + i, i == N - 1);
    idle();
    chk("t4_next_slot0", 64'(m_a[0 +: DW]), 64'h0000_0E00);
    chk("t4_next_slot6", 64'(m_a[6*DW +: DW]), 64'h0000_0E06);

    // 18-word frame
    for (int i = 0; i < 18; i++) begin
      send_word(32'h0000_0F00 + i, i == 17);
      if (i == 14) begin
        chk("t5_err_long", 64'(err_long), 64'd1);
        chk("t5_valid", 64'(m_valid), 64'd1);
        chk("t5_slot14", 64'(m_a[14*DW +: DW]), 64'h0000_0F0E);
      end
      if (i == 15) chk("t5_err_long_clr", 64'(err_long), 64'd0);
    end
    idle();
    for (int i = 0; i < N; i++) send_word(32'h0000_1100 + i, i == N - 1);
    idle();
    chk("t5_next_slot0", 64'(m_a[0 +: DW]), 64'h0000_1100);
    chk("t5_next_slot14", 64'(m_a[14*DW +: DW]), 64'h0000_110E);
    @(negedge clk);

    // Reset mid-frame with a frame held on the output
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) send_word(32'h0000_2200 + i, i == N - 1);
    for (int i = 0; i < 8; i++) send_word(32'h0000_2300 + i, 1'b0);
    s_valid = 1'b1; s_data = 32'h0000_2308; s_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    chk("t6_m_a", 64'(|m_a), 64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) send_word(32'h0000_2400 + i, i == N - 1);
    idle();
    chk("t6_fresh_slot0", 64'(m_a[0 +: DW]), 64'h0000_2400);
    chk("t6_fresh_slot14", 64'(m_a[14*DW +: DW]), 64'h0000_240E);
    @(negedge clk);
    chk("t6_frame_cnt_after", 64'(frame_cnt), 64'd1);
    chk("t6_no_errs", 64'({err_short, err_long}), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
